// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage in front of the main decoder. Owns the fetch PC, issues
//   word reads to instruction memory over a req/ack handshake, and holds the
//   fetched word in an instruction register presented downstream through a
//   valid/ready handshake (instr[31:26] is the decoder Op). Redirects from the
//   datapath (taken branches, jumps) override everything and squash any
//   wrong-path fetch still in flight.
//
// Ports
//   clk            rising-edge clock
//   reset_n        synchronous reset, active low
//   imem_req       read request, high exactly while a read is outstanding
//   imem_addr      word-aligned read address, stable while imem_req is high
//   imem_ack       read complete, imem_rdata valid this cycle
//   imem_rdata     read data
//   instr_valid    instr/instr_pc hold a valid instruction
//   instr_ready    decode accepts the instruction this cycle
//   instr          instruction register
//   instr_pc       address of instr
//   pc_plus4       instr_pc + 4
//   redirect_valid one-cycle redirect pulse
//   redirect_pc    redirect target, bits [1:0] forced to zero
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  logic [1:0]  state_q,       state_d;
  logic [31:0] fetch_pc_q,    fetch_pc_d;
  logic        imem_req_q,    imem_req_d;
  logic [31:0] imem_addr_q,   imem_addr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q,       instr_d;
  logic [31:0] instr_pc_q,    instr_pc_d;
  logic [31:0] pc_plus4_q,    pc_plus4_d;

  logic [31:0] redirect_tgt_s;
  logic [31:0] addr_plus4_s;
  logic        redirect_lsb_unused;

  // Redirect targets are always word aligned; the low bits are dropped.
  assign redirect_tgt_s      = {redirect_pc[31:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];
  // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0.
  assign addr_plus4_s        = imem_addr_q + 32'd4;

  // Next-state and datapath update; a redirect takes priority in every state.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    imem_addr_d   = imem_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    pc_plus4_d    = pc_plus4_q;

    case (state_q)
      ST_FETCH: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_tgt_s;
        end else begin
          imem_addr_d = fetch_pc_q;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          // An acked read is simply discarded; an outstanding one must still
          // complete on the old address, so its data is dropped later.
          fetch_pc_d = redirect_tgt_s;
          state_d    = imem_ack ? ST_FETCH : ST_DROP;
        end else if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_pc_d    = imem_addr_q;
          pc_plus4_d    = addr_plus4_s;
          fetch_pc_d    = addr_plus4_s;
          instr_valid_d = 1'b1;
          state_d       = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          // Flush even if decode is accepting this cycle.
          instr_valid_d = 1'b0;
          fetch_pc_d    = redirect_tgt_s;
          state_d       = ST_FETCH;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DROP: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_tgt_s;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        if (imem_ack) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        instr_valid_d = 1'b0;
        state_d       = ST_FETCH;
      end
    endcase
  end

  // The request is a registered decode of the next state (WAIT or DROP).
  always_comb begin
    imem_req_d = (state_d == ST_WAIT) || (state_d == ST_DROP);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_FETCH;
      fetch_pc_q    <= RESET_PC;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h0000_0000;
      instr_pc_q    <= 32'h0000_0000;
      pc_plus4_q    <= 32'h0000_0004;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      pc_plus4_q    <= pc_plus4_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_plus4    = pc_plus4_q;

endmodule
